// File: rtl/ballot_booth_scheduler.sv
// Poll-session controller that shares one tally port among NUM_BOOTHS booths.
// It handles key unlock and close, arms booths one voter at a time, and round-robin arbitrates ballots.
module ballot_booth_scheduler #(
    parameter int          NUM_BOOTHS = 4,
    parameter int          CAND_W     = 2,
    parameter int          NUM_CAND   = 3,
    parameter logic [3:0]  KEY_CODE   = 4'hF,
    parameter int          TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   key_val,
    input  logic                         poll_close,
    input  logic [NUM_BOOTHS-1:0]        arm_req,
    input  logic [NUM_BOOTHS-1:0]        booth_req,
    input  logic [NUM_BOOTHS*CAND_W-1:0] booth_cand,
    output logic [NUM_BOOTHS-1:0]        booth_armed,
    output logic [NUM_BOOTHS-1:0]        booth_ack,
    output logic                         vote_valid,
    output logic [CAND_W-1:0]            vote_cand,
    output logic [2:0]                   vote_booth,
    output logic [1:0]                   state,
    output logic [15:0]                  votes_cast
);

    localparam int PW = $clog2(NUM_BOOTHS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CAND_W:0] CAND_LIMIT = (CAND_W + 1)'(NUM_CAND);

    typedef enum logic [1:0] {
        LOCKED  = 2'b00,
        OPEN    = 2'b01,
        CLOSING = 2'b10,
        CLOSED  = 2'b11
    } state_t;

    state_t                  state_reg, state_next;
    logic                    arm_en, vote_en;
    logic [PW-1:0]           ptr_reg, ptr_next;
    logic [NUM_BOOTHS-1:0]   armed_reg, ack_reg;
    logic [TW-1:0]           timer_reg [NUM_BOOTHS];
    logic [NUM_BOOTHS-1:0]   cand_ok, eligible, grant_vec;
    logic                    grant_any;
    logic [PW-1:0]           grant_idx;
    logic [CAND_W-1:0]       grant_cand;
    logic                    vote_valid_reg;
    logic [CAND_W-1:0]       vote_cand_reg;
    logic [2:0]              vote_booth_reg;
    logic [15:0]             votes_cast_reg;

    assign state       = state_reg;
    assign booth_armed = armed_reg;
    assign booth_ack   = ack_reg;
    assign vote_valid  = vote_valid_reg;
    assign vote_cand   = vote_cand_reg;
    assign vote_booth  = vote_booth_reg;
    assign votes_cast  = votes_cast_reg;

    // Session FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOCKED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Session FSM: next state and phase enables
    always_comb begin
        state_next = state_reg;
        arm_en     = 1'b0;
        vote_en    = 1'b0;
        case (state_reg)
            LOCKED: begin
                if (key_val == KEY_CODE) state_next = OPEN;
            end
            OPEN: begin
                arm_en  = 1'b1;
                vote_en = 1'b1;
                if (poll_close) state_next = CLOSING;
            end
            CLOSING: begin
                vote_en = 1'b1;
                if (armed_reg == '0) state_next = CLOSED;
            end
            default: begin
                state_next = CLOSED;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOOTHS; gi++) begin : g_booth
            assign cand_ok[gi]  = {1'b0, booth_cand[gi*CAND_W +: CAND_W]} < CAND_LIMIT;
            assign eligible[gi] = armed_reg[gi] & booth_req[gi] & cand_ok[gi] & vote_en;

            // A grant takes priority over both timeout and re-arm of the same booth
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    armed_reg[gi] <= 1'b0;
                    ack_reg[gi]   <= 1'b0;
                    timer_reg[gi] <= '0;
                end else begin
                    ack_reg[gi] <= grant_vec[gi];
                    if (grant_vec[gi]) begin
                        armed_reg[gi] <= 1'b0;
                        timer_reg[gi] <= '0;
                    end else if (armed_reg[gi]) begin
                        if (timer_reg[gi] == TW'(1)) begin
                            armed_reg[gi] <= 1'b0;
                            timer_reg[gi] <= '0;
                        end else begin
                            timer_reg[gi] <= timer_reg[gi] - TW'(1);
                        end
                    end else if (arm_en && arm_req[gi]) begin
                        armed_reg[gi] <= 1'b1;
                        timer_reg[gi] <= TW'(TIMEOUT);
                    end
                end
            end
        end
    endgenerate

    // Rotating search starting at the round-robin pointer; first hit wins
    always_comb begin
        int j;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_vec  = '0;
        grant_cand = '0;
        j          = 0;
        for (int k = 0; k < NUM_BOOTHS; k++) begin
            j = (int'(ptr_reg) + k) % NUM_BOOTHS;
            if (!grant_any && eligible[j]) begin
                grant_any    = 1'b1;
                grant_idx    = PW'(j);
                grant_vec[j] = 1'b1;
                grant_cand   = booth_cand[j*CAND_W +: CAND_W];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == PW'(NUM_BOOTHS - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg        <= '0;
            vote_valid_reg <= 1'b0;
            vote_cand_reg  <= '0;
            vote_booth_reg <= '0;
            votes_cast_reg <= '0;
        end else begin
            ptr_reg        <= ptr_next;
            vote_valid_reg <= grant_any;
            if (grant_any) begin
                vote_cand_reg  <= grant_cand;
                vote_booth_reg <= 3'(grant_idx);
                if (votes_cast_reg != 16'hFFFF) votes_cast_reg <= votes_cast_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ballot_booth_scheduler.sv
// Directed bench for ballot_booth_scheduler. Stimulus pushes expected votes into a queue,
// and a negedge monitor pops and compares them whenever vote_valid is seen.
module tb_ballot_booth_scheduler;

    localparam int NB = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      key_val = '0;
    logic            poll_close = 1'b0;
    logic [NB-1:0]   arm_req = '0;
    logic [NB-1:0]   booth_req = '0;
    logic [NB*CW-1:0] booth_cand = '0;
    logic [NB-1:0]   booth_armed;
    logic [NB-1:0]   booth_ack;
    logic            vote_valid;
    logic [CW-1:0]   vote_cand;
    logic [2:0]      vote_booth;
    logic [1:0]      state;
    logic [15:0]     votes_cast;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [2:0]  booth;
        logic [1:0]  cand;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    ballot_booth_scheduler #(
        .NUM_BOOTHS(NB), .CAND_W(CW), .NUM_CAND(3), .KEY_CODE(4'hF), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .key_val(key_val), .poll_close(poll_close),
        .arm_req(arm_req), .booth_req(booth_req), .booth_cand(booth_cand),
        .booth_armed(booth_armed), .booth_ack(booth_ack), .vote_valid(vote_valid),
        .vote_cand(vote_cand), .vote_booth(vote_booth), .state(state),
        .votes_cast(votes_cast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int c, input int n);
        exp_t e;
        e.booth = 3'(b);
        e.cand  = 2'(c);
        e.cnt   = 16'(n);
        exp_q.push_back(e);
    endtask

    // Monitor: every observed vote must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (vote_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vote_booth", {29'd0, vote_booth}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("vote_booth", {29'd0, vote_booth}, {29'd0, e.booth});
                check("vote_cand",  {30'd0, vote_cand},  {30'd0, e.cand});
                check("votes_cast", {16'd0, votes_cast}, {16'd0, e.cnt});
                check("booth_ack",  {28'd0, booth_ack},  32'(4'b0001 << e.booth));
            end
        end else if (booth_ack != '0) begin
            check("ack_without_vote", {28'd0, booth_ack}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, wrong key ignored, right key opens
        tick(2);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_armed", {28'd0, booth_armed}, 32'd0);
        check("rst_vote_valid", {31'd0, vote_valid}, 32'd0);
        check("rst_votes_cast", {16'd0, votes_cast}, 32'd0);
        rst = 1'b0;
        key_val = 4'h3;
        tick(5);
        check("wrong_key_state", {30'd0, state}, 32'd0);
        key_val = 4'hF;
        tick(1);
        check("open_state", {30'd0, state}, 32'd1);
        key_val = 4'h0;

        // 2: four booths vote back to back
        arm_req = 4'hF;
        tick(1);
        arm_req = '0;
        check("all_armed", {28'd0, booth_armed}, 32'hF);
        booth_cand = {2'd1, 2'd2, 2'd1, 2'd0};
        booth_req  = 4'hF;
        push(0, 0, 1); push(1, 1, 2); push(2, 2, 3); push(3, 1, 4);
        tick(4);
        check("votes_after_four", {16'd0, votes_cast}, 32'd4);
        check("none_armed", {28'd0, booth_armed}, 32'd0);
        booth_req = '0;

        // 3: booth 1 vote leaves pointer at 2, so booth 3 beats booth 0
        arm_req = 4'b0010;
        tick(1);
        arm_req = '0;
        booth_cand = {2'd0, 2'd0, 2'd2, 2'd0};
        booth_req  = 4'b0010;
        push(1, 2, 5);
        tick(1);
        booth_req = '0;
        arm_req = 4'b1001;
        tick(1);
        arm_req = '0;
        booth_cand = {2'd0, 2'd0, 2'd0, 2'd1};
        booth_req  = 4'b1001;
        push(3, 0, 6); push(0, 1, 7);
        tick(2);
        booth_req = '0;
        tick(1);
        check("rr_armed_clear", {28'd0, booth_armed}, 32'd0);

        // 4: invalid candidate never granted, booth times out after 8 cycles
        arm_req = 4'b0100;
        tick(1);
        arm_req = '0;
        booth_cand = {2'd0, 2'd3, 2'd0, 2'd0};
        booth_req  = 4'b0100;
        tick(7);
        check("invalid_still_armed", {28'd0, booth_armed}, 32'h4);
        tick(1);
        check("invalid_timed_out", {28'd0, booth_armed}, 32'd0);
        check("invalid_votes_cast", {16'd0, votes_cast}, 32'd7);
        check("hold_vote_booth", {29'd0, vote_booth}, 32'd0);
        check("hold_vote_cand", {30'd0, vote_cand}, 32'd1);
        booth_req = '0;

        // 5: close with booths 1 and 2 armed; 1 votes, 2 times out
        arm_req = 4'b0110;
        tick(1);
        arm_req = '0;
        poll_close = 1'b1;
        booth_cand = {2'd0, 2'd0, 2'd1, 2'd0};
        booth_req  = 4'b0010;
        push(1, 1, 8);
        tick(1);
        check("closing_state", {30'd0, state}, 32'd2);
        poll_close = 1'b0;
        booth_req  = '0;
        tick(6);
        check("closing_b2_armed", {28'd0, booth_armed}, 32'h4);
        tick(1);
        check("closing_all_clear", {28'd0, booth_armed}, 32'd0);
        check("still_closing", {30'd0, state}, 32'd2);
        tick(1);
        check("closed_state", {30'd0, state}, 32'd3);
        arm_req = 4'hF;
        key_val = 4'hF;
        tick(1);
        arm_req = '0;
        tick(1);
        check("closed_arm_ignored", {28'd0, booth_armed}, 32'd0);
        check("closed_terminal", {30'd0, state}, 32'd3);
        check("closed_votes_cast", {16'd0, votes_cast}, 32'd8);

        // 6: async reset right after a grant kills the vote strobe
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        key_val = 4'h0;
        check("reopen_state", {30'd0, state}, 32'd1);
        arm_req = 4'b0001;
        tick(1);
        arm_req = '0;
        booth_cand = {2'd0, 2'd0, 2'd0, 2'd2};
        booth_req  = 4'b0001;
        tick(1);
        check("pre_rst_vote_valid", {31'd0, vote_valid}, 32'd1);
        rst = 1'b1;
        booth_req = '0;
        #1;
        check("rst_kills_vote", {31'd0, vote_valid}, 32'd0);
        check("rst_clears_count", {16'd0, votes_cast}, 32'd0);
        check("rst_to_locked", {30'd0, state}, 32'd0);
        check("rst_clears_ack", {28'd0, booth_ack}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
